// File: rtl/cam_frame_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cam_frame_capture
// Purpose  : Frame-aware DVP camera pixel capture running on the system
//            clock. Oversamples cam_pclk/vsync/href/data, assembles 1- or
//            2-byte pixels (MSB byte first), tracks row/column against the
//            configured frame size and queues tagged pixels in a small FIFO
//            with a valid/ready output handshake.
// Ports    : clk, reset (async, active-high)   - system clock / reset
//            enable                            - capture enable (frame bound)
//            cam_pclk/vsync/href/data          - asynchronous camera pins
//            decim (CAM_FRAME_CAPTURE_DECIM_EN) - 2x2 decimation select
//            pix_valid/pix_ready/pix_data/pix_col/pix_row/pix_sof/pix_eol
//                                              - FIFO head and handshake
//            frame_done                        - 1-cycle end-of-frame pulse
//            overflow, size_err                - sticky error flags
// Options  : define CAM_FRAME_CAPTURE_DECIM_EN to add the decim input.
// Revision : 1.0 - initial release
// ============================================================================
module cam_frame_capture #(
  parameter int BYTES_PER_PIXEL = 2,
  parameter int FRAME_COLS      = 320,
  parameter int FRAME_ROWS      = 240,
  parameter int FIFO_DEPTH      = 8,
  parameter int COL_W           = 9,
  parameter int ROW_W           = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         cam_pclk,
  input  logic                         cam_vsync,
  input  logic                         cam_href,
  input  logic [7:0]                   cam_data,
`ifdef CAM_FRAME_CAPTURE_DECIM_EN
  input  logic                         decim,
`endif
  output logic                         pix_valid,
  input  logic                         pix_ready,
  output logic [8*BYTES_PER_PIXEL-1:0] pix_data,
  output logic [COL_W-1:0]             pix_col,
  output logic [ROW_W-1:0]             pix_row,
  output logic                         pix_sof,
  output logic                         pix_eol,
  output logic                         frame_done,
  output logic                         overflow,
  output logic                         size_err
);

  localparam int c_pix_w = 8 * BYTES_PER_PIXEL;
  localparam int c_aw    = $clog2(FIFO_DEPTH);
  localparam int c_ent_w = c_pix_w + COL_W + ROW_W + 2;

  localparam logic [COL_W:0] c_cols      = (COL_W+1)'(FRAME_COLS);
  localparam logic [COL_W:0] c_col_last  = (COL_W+1)'(FRAME_COLS - 1);
  localparam logic [COL_W:0] c_col_last2 = (COL_W+1)'(FRAME_COLS - 2);
  localparam logic [ROW_W:0] c_rows      = (ROW_W+1)'(FRAME_ROWS);
  localparam logic [1:0]     c_last_ph   = 2'(BYTES_PER_PIXEL - 1);
  localparam logic [c_aw:0]  c_depth     = (c_aw+1)'(FIFO_DEPTH);

  localparam logic [1:0] c_idle       = 2'd0;
  localparam logic [1:0] c_wait_blank = 2'd1;
  localparam logic [1:0] c_wait_start = 2'd2;
  localparam logic [1:0] c_active     = 2'd3;

  // --------------------------------------------------------------------------
  // Input synchronisers (2 flops each) plus one delay stage for edge detect
  // --------------------------------------------------------------------------
  logic       r_pclk_s1, r_pclk_s2, r_pclk_d;
  logic       r_vsync_s1, r_vsync_s2, r_vsync_d;
  logic       r_href_s1, r_href_s2, r_href_d;
  logic [7:0] r_data_s1, r_data_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pclk_s1  <= 1'b0; r_pclk_s2  <= 1'b0; r_pclk_d  <= 1'b0;
      r_vsync_s1 <= 1'b0; r_vsync_s2 <= 1'b0; r_vsync_d <= 1'b0;
      r_href_s1  <= 1'b0; r_href_s2  <= 1'b0; r_href_d  <= 1'b0;
      r_data_s1  <= 8'h00; r_data_s2 <= 8'h00;
    end else begin
      r_pclk_s1  <= cam_pclk;  r_pclk_s2  <= r_pclk_s1;  r_pclk_d  <= r_pclk_s2;
      r_vsync_s1 <= cam_vsync; r_vsync_s2 <= r_vsync_s1; r_vsync_d <= r_vsync_s2;
      r_href_s1  <= cam_href;  r_href_s2  <= r_href_s1;  r_href_d  <= r_href_s2;
      r_data_s1  <= cam_data;  r_data_s2  <= r_data_s1;
    end
  end

  logic w_pclk_rise, w_vsync_rise, w_vsync_fall, w_href_fall;
  assign w_pclk_rise  = r_pclk_s2 & ~r_pclk_d;
  assign w_vsync_rise = r_vsync_s2 & ~r_vsync_d;
  assign w_vsync_fall = ~r_vsync_s2 & r_vsync_d;
  assign w_href_fall  = ~r_href_s2 & r_href_d;

  // --------------------------------------------------------------------------
  // Frame state machine
  // --------------------------------------------------------------------------
  logic [1:0] r_state, w_state_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_idle;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:       if (enable)       w_state_nxt = c_wait_blank;
      c_wait_blank: if (r_vsync_s2)   w_state_nxt = c_wait_start;
      c_wait_start: if (w_vsync_fall) w_state_nxt = c_active;
      c_active:     if (w_vsync_rise) w_state_nxt = enable ? c_wait_start : c_idle;
      default:                        w_state_nxt = c_idle;
    endcase
  end

  logic w_frame_start, w_active, w_clear_sticky;
  always_comb begin
    w_frame_start  = 1'b0;
    w_active       = 1'b0;
    w_clear_sticky = 1'b0;
    frame_done     = 1'b0;
    case (r_state)
      c_idle:       w_clear_sticky = enable;
      c_wait_start: w_frame_start  = w_vsync_fall;
      c_active: begin
        w_active   = 1'b1;
        frame_done = w_vsync_rise;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Decimation select, frozen for the whole frame
  // --------------------------------------------------------------------------
  logic w_decim;
`ifdef CAM_FRAME_CAPTURE_DECIM_EN
  logic r_decim;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              r_decim <= 1'b0;
    else if (w_frame_start) r_decim <= decim;
  end
  assign w_decim = r_decim;
`else
  assign w_decim = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Byte assembly and row/column tracking
  // --------------------------------------------------------------------------
  logic [c_pix_w-1:0] r_shift, w_shift_next;
  logic [1:0]         r_phase;
  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;

  logic w_byte, w_pix_done, w_oversize, w_keep, w_push, w_line_bad, w_frame_bad;

  // A full pixel is taken straight from the incoming byte, so the FIFO entry
  // is ready on the detection cycle of the last byte.
  assign w_shift_next = (r_shift << 8) | c_pix_w'(r_data_s2);
  assign w_byte       = w_active & w_pclk_rise & r_href_s2;
  assign w_pix_done   = w_byte & (r_phase == c_last_ph);
  assign w_oversize   = ({1'b0, r_col} >= c_cols) | ({1'b0, r_row} >= c_rows);
  assign w_keep       = ~w_decim | (~r_col[0] & ~r_row[0]);
  assign w_push       = w_pix_done & ~w_oversize & w_keep;
  assign w_line_bad   = w_active & w_href_fall & (({1'b0, r_col} != c_cols) | (r_phase != 2'd0));
  assign w_frame_bad  = frame_done & ({1'b0, r_row} != c_rows);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_phase <= 2'd0;
      r_col   <= '0;
      r_row   <= '0;
    end else if (w_frame_start) begin
      r_phase <= 2'd0;
      r_col   <= '0;
      r_row   <= '0;
    end else if (w_active) begin
      if (w_byte) begin
        r_shift <= w_shift_next;
        if (w_pix_done) begin
          r_phase <= 2'd0;
          if (r_col != '1) r_col <= r_col + 1'b1;
        end else begin
          r_phase <= r_phase + 2'd1;
        end
      end
      if (w_href_fall) begin
        r_phase <= 2'd0;
        r_col   <= '0;
        if (r_row != '1) r_row <= r_row + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output FIFO
  // --------------------------------------------------------------------------
  logic [c_ent_w-1:0] r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]    r_wr_ptr, r_rd_ptr;
  logic [c_aw:0]      r_count;
  logic [COL_W-1:0]   w_col_rep;
  logic [ROW_W-1:0]   w_row_rep;
  logic               w_sof, w_eol, w_pop, w_full, w_wr;
  logic [c_ent_w-1:0] w_entry;

  assign w_col_rep = w_decim ? (r_col >> 1) : r_col;
  assign w_row_rep = w_decim ? (r_row >> 1) : r_row;
  assign w_sof     = (r_col == '0) & (r_row == '0);
  assign w_eol     = w_decim ? ({1'b0, r_col} == c_col_last2) : ({1'b0, r_col} == c_col_last);
  assign w_entry   = {w_shift_next, w_col_rep, w_row_rep, w_sof, w_eol};

  assign pix_valid = (r_count != '0);
  assign w_pop     = pix_valid & pix_ready;
  assign w_full    = (r_count == c_depth);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_wr      = w_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{c_aw{1'b0}}, w_wr} - {{c_aw{1'b0}}, w_pop};
    end
  end

  // Head fields are forced to zero while empty so stale memory never shows.
  assign {pix_data, pix_col, pix_row, pix_sof, pix_eol} = pix_valid ? r_mem[r_rd_ptr] : '0;

  // --------------------------------------------------------------------------
  // Sticky error flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      size_err <= 1'b0;
    end else if (w_clear_sticky) begin
      overflow <= 1'b0;
      size_err <= 1'b0;
    end else begin
      if (w_push & w_full & ~w_pop)                      overflow <= 1'b1;
      if ((w_pix_done & w_oversize) | w_line_bad | w_frame_bad) size_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cam_frame_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cam_frame_capture
// Purpose  : Directed self-checking bench for cam_frame_capture using a
//            4x2 frame, 2-byte pixels and a 4-entry FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cam_frame_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        cam_pclk = 1'b0;
  logic        cam_vsync = 1'b1;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic        pix_ready = 1'b0;
`ifdef CAM_FRAME_CAPTURE_DECIM_EN
  logic        decim = 1'b0;
`endif
  logic        pix_valid;
  logic [15:0] pix_data;
  logic [8:0]  pix_col;
  logic [7:0]  pix_row;
  logic        pix_sof, pix_eol, frame_done, overflow, size_err;

  cam_frame_capture #(
    .BYTES_PER_PIXEL(2), .FRAME_COLS(4), .FRAME_ROWS(2),
    .FIFO_DEPTH(4), .COL_W(9), .ROW_W(8)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data),
`ifdef CAM_FRAME_CAPTURE_DECIM_EN
    .decim(decim),
`endif
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_col(pix_col), .pix_row(pix_row), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .frame_done(frame_done), .overflow(overflow), .size_err(size_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic [8:0]  c;
    logic [7:0]  r;
    logic        s;
    logic        e;
  } pix_t;

  pix_t q[$];
  int   fd_cnt = 0;
  int   n_vec  = 0;
  int   n_err  = 0;
  logic [7:0] nb;

  // Consumer-side monitor: a pixel is accepted in any cycle with valid & ready.
  always @(negedge clk) begin
    pix_t p;
    if (pix_valid && pix_ready) begin
      p.d = pix_data; p.c = pix_col; p.r = pix_row; p.s = pix_sof; p.e = pix_eol;
      q.push_back(p);
    end
    if (frame_done) fd_cnt++;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 pix_ready = v;
  endtask

  task automatic send_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      cam_pclk = 1'b0;
      cam_data = nb;
      nb       = nb + 8'd1;
      #30 cam_pclk = 1'b1;
      #30;
    end
  endtask

  task automatic send_line(input int npix);
    cam_href = 1'b1;
    send_bytes(2 * npix);
    cam_pclk = 1'b0;
    cam_href = 1'b0;
    #60;
  endtask

  task automatic send_frame(input int cols0, input int cols1);
    cam_vsync = 1'b1;
    #100 cam_vsync = 1'b0;
    nb = 8'h10;
    #100;
    send_line(cols0);
    send_line(cols1);
    cam_vsync = 1'b1;
    #100;
  endtask

  // Pixel k of a 4-wide frame carries bytes 0x10+2k, 0x11+2k.
  task automatic check_pixels(input int first_q, input int first_k, input int n);
    for (int i = 0; i < n; i++) begin
      int   k;
      pix_t p;
      logic [7:0] hi;
      k  = first_k + i;
      hi = 8'(16 + 2 * k);
      if (first_q + i < q.size()) begin
        p = q[first_q + i];
        check_value($sformatf("pix%0d_data", k), {16'h0, p.d}, {16'h0, hi, hi + 8'd1});
        check_value($sformatf("pix%0d_col", k), {23'h0, p.c}, k % 4);
        check_value($sformatf("pix%0d_row", k), {24'h0, p.r}, k / 4);
        check_value($sformatf("pix%0d_sof", k), {31'h0, p.s}, {31'h0, (k == 0)});
        check_value($sformatf("pix%0d_eol", k), {31'h0, p.e}, {31'h0, (k % 4 == 3)});
      end
    end
  endtask

  initial begin
    int fd0;

    // Reset state
    #12;
    check_value("rst_valid", {31'h0, pix_valid}, 0);
    check_value("rst_data", {16'h0, pix_data}, 0);
    check_value("rst_sof_eol", {30'h0, pix_sof, pix_eol}, 0);
    check_value("rst_flags", {29'h0, frame_done, overflow, size_err}, 0);
    #11 reset = 1'b0;
    enable = 1'b1;
    set_ready(1'b1);

    // Normal 4x2 frame
    fd0 = fd_cnt;
    send_frame(4, 4);
    #100;
    check_value("t1_count", q.size(), 8);
    check_pixels(0, 0, 8);
    check_value("t1_frame_done", fd_cnt - fd0, 1);
    check_value("t1_size_err", {31'h0, size_err}, 0);
    check_value("t1_overflow", {31'h0, overflow}, 0);

    // Back-pressure: first 4 held, last 4 dropped
    q.delete();
    set_ready(1'b0);
    send_frame(4, 4);
    #100;
    check_value("t2_none_taken", q.size(), 0);
    check_value("t2_valid", {31'h0, pix_valid}, 1);
    check_value("t2_head", {16'h0, pix_data}, 32'h1011);
    check_value("t2_overflow", {31'h0, overflow}, 1);
    #200;
    check_value("t2_head_hold", {16'h0, pix_data}, 32'h1011);
    set_ready(1'b1);
    #100;
    check_value("t2_drain_count", q.size(), 4);
    check_pixels(0, 0, 4);
    check_value("t2_overflow_sticky", {31'h0, overflow}, 1);

    // Over-long first line: 5th pixel dropped, size_err set
    q.delete();
    send_frame(5, 4);
    #100;
    check_value("t3_count", q.size(), 8);
    if (q.size() == 8) begin
      check_value("t3_last_row0", {16'h0, q[3].d}, 32'h1617);
      check_value("t3_row1_first", {16'h0, q[4].d}, 32'h1A1B);
      check_value("t3_row1_pos", {14'h0, q[4].c, q[4].r}, {14'h0, 9'd0, 8'd1});
      check_value("t3_row1_last", {16'h0, q[7].d}, 32'h2021);
    end
    check_value("t3_size_err", {31'h0, size_err}, 1);
    q.delete();
    send_frame(4, 4);
    #100;
    check_value("t3_good_count", q.size(), 8);
    check_value("t3_size_err_sticky", {31'h0, size_err}, 1);

    // enable dropped in row 1: frame completes, then IDLE
    q.delete();
    fd0 = fd_cnt;
    #100 cam_vsync = 1'b0;
    nb = 8'h10;
    #100;
    send_line(4);
    fork
      send_line(4);
      #200 enable = 1'b0;
    join
    cam_vsync = 1'b1;
    #200;
    check_value("t4_count", q.size(), 8);
    check_pixels(0, 0, 8);
    check_value("t4_frame_done", fd_cnt - fd0, 1);
    q.delete();
    send_frame(4, 4);
    #100;
    check_value("t4_idle_no_pix", q.size(), 0);
    check_value("t4_idle_no_done", fd_cnt - fd0, 1);
    check_value("t4_sticky_held", {30'h0, overflow, size_err}, 3);
    enable = 1'b1;
    #50;
    check_value("t4_sticky_clear", {30'h0, overflow, size_err}, 0);

    // Reset mid-line with 3 pixels queued
    q.delete();
    set_ready(1'b0);
    #100 cam_vsync = 1'b0;
    nb = 8'h10;
    #100;
    cam_href = 1'b1;
    send_bytes(6);
    #60;
    check_value("t5_pre_valid", {31'h0, pix_valid}, 1);
    #3 reset = 1'b1;
    #1;
    check_value("t5_rst_valid", {31'h0, pix_valid}, 0);
    check_value("t5_rst_data", {16'h0, pix_data}, 0);
    check_value("t5_rst_pos", {15'h0, pix_col, pix_row}, 0);
    check_value("t5_rst_flags", {27'h0, pix_sof, pix_eol, frame_done, overflow, size_err}, 0);
    #20 reset = 1'b0;
    set_ready(1'b1);
    send_bytes(2);
    cam_pclk = 1'b0;
    cam_href = 1'b0;
    #60;
    send_line(4);
    cam_vsync = 1'b1;
    #100;
    check_value("t5_aborted_frame", q.size(), 0);
    send_frame(4, 4);
    #100;
    check_value("t5_restart_count", q.size(), 8);
    check_pixels(0, 0, 8);

`ifdef CAM_FRAME_CAPTURE_DECIM_EN
    // 2x2 decimation on a 4x2 frame
    q.delete();
    decim = 1'b1;
    send_frame(4, 4);
    #100;
    check_value("dec_count", q.size(), 2);
    if (q.size() == 2) begin
      check_value("dec0_data", {16'h0, q[0].d}, 32'h1011);
      check_value("dec0_tags", {13'h0, q[0].c, q[0].r, q[0].s, q[0].e}, {13'h0, 9'd0, 8'd0, 1'b1, 1'b0});
      check_value("dec1_data", {16'h0, q[1].d}, 32'h1415);
      check_value("dec1_tags", {13'h0, q[1].c, q[1].r, q[1].s, q[1].e}, {13'h0, 9'd1, 8'd0, 1'b0, 1'b1});
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
